// File: rtl/joy_db15_tx_if.sv
// rtl/joy_db15_tx_if.sv - DB15 serial joystick link: shift clock, load strobe and serial data
interface joy_db15_tx_if;
    logic joy_clk;
    logic joy_load;
    logic joy_data;

    modport master (output joy_clk, output joy_load, input joy_data);
    modport slave  (input joy_clk, input joy_load, output joy_data);
endinterface

// File: rtl/joy_db15_tx.sv
// rtl/joy_db15_tx.sv - device-side DB15 joystick serialiser emulating a 74HC165 chain
module joy_db15_tx #(
    parameter int          BTN_BITS    = 12,
    parameter int          SYNC_STAGES = 2,
    parameter logic [19:0] TIMEOUT     = 20'd960000
) (
    input  logic                clk,
    input  logic                reset,
    joy_db15_tx_if.slave        db15,
    input  logic [BTN_BITS-1:0] joy1_in,
    input  logic [BTN_BITS-1:0] joy2_in,
    output logic                frame_done,
    output logic                overrun,
    output logic                link_active
);
    localparam int W  = 2 * BTN_BITS;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t                 state;
    logic [W-1:0]           sr;
    logic [CW-1:0]          cnt;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] load_sync;
    logic                   clk_prev;
    logic                   load_prev;
    logic [19:0]            wd_cnt;

    logic         clk_s;
    logic         load_s;
    logic         clk_rise;
    logic         load_fall;
    logic [W-1:0] frame;

    assign clk_s     = clk_sync[SYNC_STAGES-1];
    assign load_s    = load_sync[SYNC_STAGES-1];
    assign clk_rise  = clk_s & ~clk_prev;
    assign load_fall = ~load_s & load_prev;
    assign frame     = {~joy2_in, ~joy1_in};

    assign db15.joy_data = sr[0];
    assign link_active   = (wd_cnt < TIMEOUT);

    // Sync chains idle at the pins' inactive levels so reset never fakes an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= '0;
            load_sync <= '1;
            clk_prev  <= 1'b0;
            load_prev <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], db15.joy_clk};
            load_sync <= {load_sync[SYNC_STAGES-2:0], db15.joy_load};
            clk_prev  <= clk_s;
            load_prev <= load_s;
        end
    end

    // Load low takes priority in every state, so a coincident shift edge is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sr         <= '1;
            cnt        <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (!load_s) begin
                state <= LOAD;
                sr    <= frame;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    LOAD: state <= SHIFT;
                    SHIFT: begin
                        if (clk_rise) begin
                            sr  <= {1'b1, sr[W-1:1]};
                            cnt <= cnt + 1'b1;
                            if (cnt == LAST_BIT) begin
                                frame_done <= 1'b1;
                                state      <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        if (clk_rise) begin
                            sr      <= {1'b1, sr[W-1:1]};
                            overrun <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Starts saturated so the link reads inactive until the first load arrives
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= TIMEOUT;
        end else if (load_fall) begin
            wd_cnt <= '0;
        end else if (wd_cnt < TIMEOUT) begin
            wd_cnt <= wd_cnt + 20'd1;
        end
    end
endmodule

// File: tb/tb_joy_db15_tx.sv
// tb/tb_joy_db15_tx.sv - self-checking bench for joy_db15_tx
module tb_joy_db15_tx;
    typedef struct {
        logic [11:0] j1;
        logic [11:0] j2;
        logic [23:0] frame;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] joy1_in = '0;
    logic [11:0] joy2_in = '0;
    logic        frame_done;
    logic        overrun;
    logic        link_active;

    int tests = 0;
    int fails = 0;
    int fd_count = 0;
    logic exp_q[$];
    vec_t vecs[4];

    joy_db15_tx_if db15();

    joy_db15_tx #(.BTN_BITS(12), .SYNC_STAGES(2), .TIMEOUT(20'd100)) dut (
        .clk         (clk),
        .reset       (reset),
        .db15        (db15),
        .joy1_in     (joy1_in),
        .joy2_in     (joy2_in),
        .frame_done  (frame_done),
        .overrun     (overrun),
        .link_active (link_active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (!reset && frame_done) fd_count <= fd_count + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic sample(input string nm);
        logic e;
        e = exp_q.pop_front();
        check(nm, int'(db15.joy_data), int'(e));
    endtask

    task automatic pulse();
        db15.joy_clk = 1'b1;
        tick(4);
        db15.joy_clk = 1'b0;
        tick(4);
    endtask

    task automatic load_frame(input logic [11:0] j1, input logic [11:0] j2);
        joy1_in = j1;
        joy2_in = j2;
        db15.joy_load = 1'b0;
        tick(10);
        db15.joy_load = 1'b1;
        tick(4);
    endtask

    task automatic run_frame(input logic [11:0] j1, input logic [11:0] j2,
                             input logic [23:0] f, input string nm);
        int fd0;
        load_frame(j1, j2);
        joy1_in = ~j1;
        joy2_in = ~j2;
        fd0 = fd_count;
        for (int k = 0; k < 24; k++) begin
            exp_q.push_back(f[k]);
            sample($sformatf("%s_bit%0d", nm, k));
            pulse();
        end
        check({nm, "_frame_done"}, fd_count - fd0, 1);
        check({nm, "_tail"}, int'(db15.joy_data), 1);
    endtask

    initial begin
        int rise;
        int n;
        int fd0;

        vecs[0] = '{12'h001, 12'h000, 24'hFFFFFE};
        vecs[1] = '{12'hFFF, 12'h800, 24'h7FF000};
        vecs[2] = '{12'hA5A, 12'h3C3, 24'hC3C5A5};
        vecs[3] = '{12'hFFF, 12'hFFF, 24'h000000};

        db15.joy_clk  = 1'b0;
        db15.joy_load = 1'b1;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_data", int'(db15.joy_data), 1);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_link", int'(link_active), 0);

        // Watchdog: rise latency after first load, then exact timeout
        db15.joy_load = 1'b0;
        rise = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (link_active) begin
                rise = i;
                break;
            end
        end
        check("wd_rise_in_3_4", int'(rise >= 3 && rise <= 4), 1);
        n = 0;
        while (link_active && n < 200) begin
            tick(1);
            n++;
        end
        check("wd_fall_cycles", n, 100);
        db15.joy_load = 1'b1;
        tick(5);

        for (int v = 0; v < 4; v++) begin
            run_frame(vecs[v].j1, vecs[v].j2, vecs[v].frame, $sformatf("vec%0d", v));
            check($sformatf("vec%0d_overrun", v), int'(overrun), 0);
        end

        // Overrun: two extra edges after a full frame
        fd0 = fd_count;
        for (int k = 0; k < 2; k++) begin
            pulse();
            exp_q.push_back(1'b1);
            sample($sformatf("ovr_data%0d", k));
        end
        check("ovr_set", int'(overrun), 1);
        check("ovr_no_frame_done", fd_count - fd0, 0);
        load_frame(vecs[0].j1, vecs[0].j2);
        check("ovr_hold_load", int'(overrun), 1);
        check("ovr_load_bit0", int'(db15.joy_data), 0);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        check("ovr_clear_reset", int'(overrun), 0);

        // Load and shift edge in the same cycle: load wins
        load_frame(vecs[0].j1, vecs[0].j2);
        for (int k = 0; k < 3; k++) pulse();
        check("ls_shifted", int'(db15.joy_data), 1);
        db15.joy_load = 1'b0;
        db15.joy_clk  = 1'b1;
        tick(6);
        db15.joy_clk  = 1'b0;
        tick(4);
        db15.joy_load = 1'b1;
        tick(4);
        check("ls_sr_is_frame", int'(db15.joy_data), 0);
        check("ls_cnt_zero", int'(dut.cnt), 0);

        // Short frame of 5 edges interrupted by load
        fd0 = fd_count;
        for (int k = 0; k < 5; k++) pulse();
        db15.joy_load = 1'b0;
        tick(10);
        db15.joy_load = 1'b1;
        check("short_no_frame_done", fd_count - fd0, 0);
        run_frame(vecs[2].j1, vecs[2].j2, vecs[2].frame, "after_short");

        // Reset mid-frame
        load_frame(vecs[2].j1, vecs[2].j2);
        for (int k = 0; k < 7; k++) pulse();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        check("mid_rst_data", int'(db15.joy_data), 1);
        check("mid_rst_state", int'(dut.state), 0);
        check("mid_rst_link", int'(link_active), 0);
        run_frame(vecs[1].j1, vecs[1].j2, vecs[1].frame, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/joy_db15_tx.md
Name: joy_db15_tx

Overview:
- Device-side model of the DB15 serial joystick adapter, the transmitter for the core's DB15 receiver.
- Takes two players' parallel button vectors and serialises them onto JOY_DATA, driven by the receiver's JOY_LOAD and JOY_CLK.
- Used for loopback self-test on the USER port and as the bench responder for receiver verification.
- Emulates a 74HC165-style chain: load while low, shift on rising clock edge, ones filled behind the frame.

Parameters:
- BTN_BITS, 12: buttons per player; frame length is 2*BTN_BITS.
- SYNC_STAGES, 2: synchroniser flops on joy_clk and joy_load (minimum 2).
- TIMEOUT, 20'd960000: clk cycles without a load pulse before link_active drops (20 ms @ 48 MHz).

Ports:
- clk  in  1  system clock, 40-50 MHz.
- reset  in  1  synchronous, active-high.
- joy_clk  in  1  shift clock from receiver, asynchronous.
- joy_load  in  1  parallel load from receiver, active-low, asynchronous.
- joy1_in  in  BTN_BITS  player 1 buttons, 1 = pressed.
- joy2_in  in  BTN_BITS  player 2 buttons, 1 = pressed.
- joy_data  out  1  serial data to receiver, active-low buttons.
- frame_done  out  1  one-cycle pulse when the last frame bit has been shifted past.
- overrun  out  1  sticky: more than 2*BTN_BITS shift edges arrived in one frame.
- link_active  out  1  high while load pulses arrive within TIMEOUT.

Behaviour:
Input conditioning and latency
- joy_clk and joy_load each pass through SYNC_STAGES flops; edges are detected on the synchronised versions.
- Pin-to-effect latency is SYNC_STAGES+1 clk cycles.

Frame definition
- F = {~joy2_in, ~joy1_in}, width W = 2*BTN_BITS.
- The shift register sr has W bits; joy_data = sr[0] at all times.

State machine
- IDLE:
  - Reset state; sr = all ones, so joy_data = 1.
  - Synchronised load low -> LOAD.
- LOAD:
  - Every cycle: sr <= F, bit counter cnt <= 0, so input changes track live.
  - Shift edges are ignored in this state.
  - Load high -> SHIFT.
- SHIFT:
  - On each joy_clk rising edge: sr <= {1'b1, sr[W-1:1]} and cnt <= cnt+1.
  - After k edges, joy_data = F[k] for k < W, and 1 for k >= W.
  - When cnt reaches W: assert frame_done for one cycle and go to DONE.
  - Load low -> LOAD (short frame, no frame_done).
- DONE:
  - A further shift edge sets overrun (sticky) and still shifts in a 1.
  - Load low -> LOAD.

Simultaneous events
- If a load-low and a shift edge are detected in the same cycle, load wins: sr <= F and no count increment.

Watchdog
- 20-bit counter, cleared on each synchronised falling edge of load.
- Saturates at TIMEOUT.
- link_active = (counter < TIMEOUT).

Reset values
- Applies at any point, including mid-frame.
- joy_data = 1, frame_done = 0, overrun = 0, link_active = 0, state IDLE.
- Watchdog counter = TIMEOUT, so the link reads inactive until the first load.
- overrun clears only on reset.

Sampling and wrap-around
- Button inputs are sampled only in LOAD; changes during SHIFT do not affect the frame in flight.
- cnt is wide enough for W+1 and never wraps; it holds at W in DONE.

Test Plan:
- Load/shift, player 1: reset, BTN_BITS=12, joy1_in=12'h001, joy2_in=0; pulse load low 10 cycles, then 24 shift pulses (8-cycle period).
  - Required: joy_data=0 on bit 0, 1 on bits 1-23.
  - Required: exactly one frame_done after the 24th edge.
  - Required: overrun=0.
- Bit ordering, player 2: joy2_in=12'h800, joy1_in=12'hFFF.
  - Required: bits 0-11 read 0.
  - Required: bit 23 reads 0.
  - Required: bits 12-22 read 1.
- Overrun: after a full frame, send 2 extra shift pulses.
  - Required: joy_data stays 1.
  - Required: overrun=1, and it holds through the next load.
  - Required: overrun clears only on reset.
- Load versus shift: assert load low and rise clk in the same cycle.
  - Required: sr equals F and cnt=0.
  - Required: a short frame of 5 edges followed by load gives no frame_done.
- Watchdog: TIMEOUT=100.
  - Required: link_active rises 3-4 cycles after the first load.
  - Required: link_active falls exactly 100 cycles after the last load falling edge with no further loads.
- Reset mid-frame: assert reset after 7 edges.
  - Required: joy_data=1, state IDLE, link_active=0.
  - Required: the next load produces a correct full frame.
